// File: rtl/bitstream_pkg.sv
// Shared types for the stochastic bitstream datapath (generator and decoder sides).
package bitstream_pkg;

   localparam int WINDOW_DEFAULT = 255;
   localparam int CW_DEFAULT     = $clog2(WINDOW_DEFAULT + 1);

   typedef logic [CW_DEFAULT-1:0] count_t;

   typedef enum logic [1:0] {
      IDLE,
      WARM,
      RUN
   } dec_state_t;

endpackage

// File: rtl/window_counter.sv
// Counts ones of a bitstream over WINDOW enabled cycles.
// done and final_count are combinational and valid on the last sample of a window.
module window_counter
   import bitstream_pkg::*;
#(
   parameter  int WINDOW = WINDOW_DEFAULT,
   localparam int CW     = $clog2(WINDOW + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clr,
   input  logic          en,
   input  logic          x,
   output logic          done,
   output logic [CW-1:0] final_count
);

   logic [CW-1:0] cyc;
   logic [CW-1:0] ones;

   assign done        = en && (cyc == CW'(WINDOW - 1));
   assign final_count = ones + CW'(x);

   // Wrap straight to zero on the last sample so windows run back-to-back.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cyc  <= '0;
         ones <= '0;
      end else if (clr || done) begin
         cyc  <= '0;
         ones <= '0;
      end else if (en) begin
         cyc  <= cyc + CW'(1);
         ones <= final_count;
      end
   end

endmodule

// File: rtl/stream_decoder.sv
// Stochastic bitstream to binary decoder: ones count per window, warm-up discard,
// valid/ready output register with sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for first enabled cycle, nothing counted yet
// WARM  | counting windows that are discarded while upstream settles
// RUN   | every completed window is presented on data/valid
module stream_decoder
   import bitstream_pkg::*;
#(
   parameter  int WINDOW = WINDOW_DEFAULT,
   parameter  int SKIP   = 1,
   localparam int CW     = $clog2(WINDOW + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          x,
   input  logic          en,
   input  logic          clr,
   output logic [CW-1:0] data,
   output logic          valid,
   input  logic          ready,
   output logic          overrun,
   output logic          busy
);

   localparam int SW = (SKIP > 0) ? $clog2(SKIP + 1) : 1;

   dec_state_t    state;
   dec_state_t    act_state;
   logic [SW-1:0] skip_cnt;
   logic          win_done;
   logic [CW-1:0] win_count;

   window_counter #(.WINDOW(WINDOW)) u_window_counter (
      .clk         (clk),
      .n_rst       (n_rst),
      .clr         (clr),
      .en          (en),
      .x           (x),
      .done        (win_done),
      .final_count (win_count)
   );

   // The enabled cycle that leaves IDLE is already a sample, so treat it as the next state.
   always_comb begin
      act_state = state;
      if (state == IDLE && en) begin
         act_state = (SKIP > 0) ? WARM : RUN;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state    <= IDLE;
         skip_cnt <= '0;
         data     <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
         busy     <= 1'b0;
      end else if (clr) begin
         state    <= IDLE;
         skip_cnt <= '0;
         data     <= '0;
         valid    <= 1'b0;
         overrun  <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state <= act_state;
         busy  <= (act_state != IDLE);
         if (valid && ready) begin
            valid <= 1'b0;
         end
         if (win_done) begin
            if (act_state == WARM) begin
               skip_cnt <= skip_cnt + SW'(1);
               if (skip_cnt == SW'(SKIP - 1)) begin
                  state <= RUN;
               end
            end else if (act_state == RUN) begin
               data  <= win_count;
               valid <= 1'b1;
               if (valid && !ready) begin
                  overrun <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_decoder.sv
// Bench for stream_decoder: two instances (SKIP=0 and SKIP=1) on shared inputs,
// a queue-based window model, a directed phase table and a randomized run.
module tb_stream_decoder;

   localparam int WINDOW = 255;
   localparam int CW     = $clog2(WINDOW + 1);

   logic          clk   = 1'b0;
   logic          n_rst = 1'b1;
   logic          x     = 1'b0;
   logic          en    = 1'b0;
   logic          clr   = 1'b0;
   logic          ready = 1'b0;
   logic [CW-1:0] data0, data1;
   logic          valid0, valid1, overrun0, overrun1, busy0, busy1;

   int total = 0;
   int bad   = 0;
   int ncyc  = 0;

   always #5 clk = ~clk;

   stream_decoder #(.WINDOW(WINDOW), .SKIP(0)) u_dut0 (
      .clk(clk), .n_rst(n_rst), .x(x), .en(en), .clr(clr),
      .data(data0), .valid(valid0), .ready(ready), .overrun(overrun0), .busy(busy0)
   );

   stream_decoder #(.WINDOW(WINDOW), .SKIP(1)) u_dut1 (
      .clk(clk), .n_rst(n_rst), .x(x), .en(en), .clr(clr),
      .data(data1), .valid(valid1), .ready(ready), .overrun(overrun1), .busy(busy1)
   );

   // Reference: enabled samples collected in a queue; a full queue is one window.
   // Window k is reported by the instance whose SKIP (equal to its index) is <= k.
   bit mq[$];
   int widx     = 0;
   bit mstarted = 1'b0;
   bit m_valid[2];
   int m_data[2];
   bit m_ovr[2];
   int msum;

   task model_clear();
      mq.delete();
      widx     = 0;
      mstarted = 1'b0;
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 1'b0;
         m_data[i]  = 0;
         m_ovr[i]   = 1'b0;
      end
   endtask

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst || clr) begin
         model_clear();
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (m_valid[i] && ready) m_valid[i] = 1'b0;
         end
         if (en) begin
            mstarted = 1'b1;
            mq.push_back(x);
            if (mq.size() == WINDOW) begin
               msum = 0;
               foreach (mq[k]) msum += int'(mq[k]);
               mq.delete();
               for (int i = 0; i < 2; i++) begin
                  if (widx >= i) begin
                     if (m_valid[i]) m_ovr[i] = 1'b1;
                     m_data[i]  = msum;
                     m_valid[i] = 1'b1;
                  end
               end
               widx++;
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0d want=%0d", name, ncyc, act, exp);
      end
   endtask

   task automatic check_model();
      chk("dut0 data",    int'(data0),    m_data[0]);
      chk("dut0 valid",   int'(valid0),   int'(m_valid[0]));
      chk("dut0 overrun", int'(overrun0), int'(m_ovr[0]));
      chk("dut0 busy",    int'(busy0),    int'(mstarted));
      chk("dut1 data",    int'(data1),    m_data[1]);
      chk("dut1 valid",   int'(valid1),   int'(m_valid[1]));
      chk("dut1 overrun", int'(overrun1), int'(m_ovr[1]));
      chk("dut1 busy",    int'(busy1),    int'(mstarted));
   endtask

   task automatic step(input bit e, input bit xx, input bit r, input bit c);
      en    = e;
      x     = xx;
      ready = r;
      clr   = c;
      @(posedge clk);
      @(negedge clk);
      ncyc++;
      check_model();
   endtask

   typedef struct {
      int n;     int en;   int ones; int rdy; int clr;
      int v1;    int d1;   int o1;
      int v0;    int d0;   int o0;
      int b;
   } phase_t;

   localparam int NPH = 18;
   phase_t ph[NPH];

   initial begin
      //        n    en ones rdy clr  v1 d1  o1  v0 d0  o0  b
      ph[0]  = '{2,   0, 0,   0,  1,   0, 0,   0,  0, 0,   0,  0};
      ph[1]  = '{255, 1, 255, 1,  0,   0, 0,   0,  1, 255, 0,  1};
      ph[2]  = '{255, 1, 100, 1,  0,   1, 100, 0,  1, 100, 0,  1};
      ph[3]  = '{255, 1, 30,  0,  0,   1, 30,  1,  1, 30,  1,  1};
      ph[4]  = '{255, 1, 40,  0,  0,   1, 40,  1,  1, 40,  1,  1};
      ph[5]  = '{1,   0, 0,   1,  0,   0, 40,  1,  0, 40,  1,  1};
      ph[6]  = '{5,   0, 0,   0,  0,   0, 40,  1,  0, 40,  1,  1};
      ph[7]  = '{100, 1, 100, 0,  0,   0, 40,  1,  0, 40,  1,  1};
      ph[8]  = '{50,  0, 50,  0,  0,   0, 40,  1,  0, 40,  1,  1};
      ph[9]  = '{155, 1, 20,  0,  0,   1, 120, 1,  1, 120, 1,  1};
      ph[10] = '{1,   0, 0,   0,  1,   0, 0,   0,  0, 0,   0,  0};
      ph[11] = '{255, 1, 5,   0,  0,   0, 0,   0,  1, 5,   0,  1};
      ph[12] = '{255, 1, 9,   0,  0,   1, 9,   0,  1, 9,   1,  1};
      ph[13] = '{254, 1, 0,   0,  0,   1, 9,   0,  1, 9,   1,  1};
      ph[14] = '{1,   1, 1,   1,  0,   1, 1,   0,  1, 1,   1,  1};
      ph[15] = '{254, 1, 254, 1,  0,   0, 1,   0,  0, 1,   1,  1};
      ph[16] = '{1,   1, 1,   1,  1,   0, 0,   0,  0, 0,   0,  0};
      ph[17] = '{610, 1, 610, 0,  0,   1, 255, 0,  1, 255, 1,  1};

      #1 n_rst = 1'b0;
      @(negedge clk);
      #2 n_rst = 1'b1;
      @(negedge clk);
      check_model();

      for (int p = 0; p < NPH; p++) begin
         for (int k = 0; k < ph[p].n; k++) begin
            step(ph[p].en != 0, k < ph[p].ones, ph[p].rdy != 0, ph[p].clr != 0);
         end
         chk($sformatf("ph%0d valid1", p),   int'(valid1),   ph[p].v1);
         chk($sformatf("ph%0d data1", p),    int'(data1),    ph[p].d1);
         chk($sformatf("ph%0d overrun1", p), int'(overrun1), ph[p].o1);
         chk($sformatf("ph%0d valid0", p),   int'(valid0),   ph[p].v0);
         chk($sformatf("ph%0d data0", p),    int'(data0),    ph[p].d0);
         chk($sformatf("ph%0d overrun0", p), int'(overrun0), ph[p].o0);
         chk($sformatf("ph%0d busy1", p),    int'(busy1),    ph[p].b);
      end

      // Asynchronous reset between clock edges while both instances hold results.
      en = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      chk("arst data0",    int'(data0),    0);
      chk("arst valid0",   int'(valid0),   0);
      chk("arst overrun0", int'(overrun0), 0);
      chk("arst busy0",    int'(busy0),    0);
      chk("arst data1",    int'(data1),    0);
      chk("arst valid1",   int'(valid1),   0);
      chk("arst overrun1", int'(overrun1), 0);
      chk("arst busy1",    int'(busy1),    0);
      #1 n_rst = 1'b1;
      @(negedge clk);
      check_model();

      // Randomized run; alternating blocks with a rarely-ready consumer to provoke overruns.
      for (int i = 0; i < 8000; i++) begin
         bit r;
         if (((i / 1000) % 2) == 1) r = ($urandom % 8) == 0;
         else                       r = 1'($urandom % 2);
         step(($urandom % 4) != 0, 1'($urandom % 2), r, ($urandom % 1500) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
